// File: rtl/spi_slave_mm_if.sv
// spi_slave_mm_if: Avalon-MM slave bus bundle for spi_slave_mm.
interface spi_slave_mm_if;
  logic [5:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        burstcount;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, burstcount, debugaccess,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount, debugaccess,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/spi_slave_mm.sv
// spi_slave_mm: Avalon-MM SPI slave with TX/RX FIFOs and an oversampled shift
// engine covering all four SPI modes.
// Optional feature macro SPI_SLAVE_IRQ_EN: adds the irq output and the IRQ_EN
// register at word address 4.
module spi_slave_mm #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_mm_if.slave bus,
  input  logic          SCLK,
  input  logic          MOSI,
  input  logic          SS_n,
  output logic          MISO
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StLoad, StXfer} state_e;

  // Register decode
  logic wr_ctrl, wr_status, wr_tx, rd_rx;
  assign wr_ctrl   = bus.write && (bus.address == 6'd0);
  assign wr_status = bus.write && (bus.address == 6'd1);
  assign wr_tx     = bus.write && (bus.address == 6'd2);
  assign rd_rx     = bus.read  && (bus.address == 6'd3);

  logic rx_flush, tx_flush;
  assign rx_flush = wr_ctrl && bus.writedata[4];
  assign tx_flush = wr_ctrl && bus.writedata[5];

  logic [3:0] ctrl_q;
  logic       rx_ovr_q, tx_unr_q;

  // Pin synchronisers {SS_n, MOSI, SCLK}: two flops plus an edge-detect flop
  logic [2:0] sync1_q, sync2_q, sync3_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b100;
      sync2_q <= 3'b100;
      sync3_q <= 3'b100;
    end else begin
      sync1_q <= {SS_n, MOSI, SCLK};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s, ss_s;
  assign sclk_rise = sync2_q[0] & ~sync3_q[0];
  assign sclk_fall = ~sync2_q[0] & sync3_q[0];
  assign mosi_s    = sync2_q[1];
  assign ss_s      = sync2_q[2];
  assign ss_fall   = ~sync2_q[2] & sync3_q[2];
  assign ss_rise   = sync2_q[2] & ~sync3_q[2];

  // FIFO state
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CNT_W-1:0]  tx_cnt_q, rx_cnt_q;
  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_W'(FIFO_DEPTH));

  // Engine state
  state_e            state_q, state_d;
  logic              f_cpol_q, f_cpha_q, f_lsb_q;
  logic [DATA_W-1:0] tx_shift_q, rx_shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              first_q, miso_q;
  logic              load, sample, shift, word_done;

  logic lead_edge, trail_edge, smp_edge, sh_edge;
  assign lead_edge  = f_cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge = f_cpol_q ? sclk_rise : sclk_fall;
  assign smp_edge   = f_cpha_q ? trail_edge : lead_edge;
  assign sh_edge    = f_cpha_q ? lead_edge : trail_edge;

  assign word_done = sample && (bit_cnt_q == BIT_W'(DATA_W - 1));

  // FIFO handshakes; a full RX only accepts when the CPU pops in the same cycle
  logic tx_take, tx_push, tx_pop, rx_push, rx_pop;
  assign tx_take = load || word_done;
  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = tx_take && !tx_empty;
  assign rx_pop  = rd_rx && !bus.debugaccess && !rx_empty;
  assign rx_push = word_done && (!rx_full || rx_pop);

  logic [DATA_W-1:0] tx_word, tx_adv, rx_next;
  assign tx_word = tx_empty ? '0 : tx_mem[tx_rd_q];
  assign tx_adv  = f_lsb_q ? (tx_shift_q >> 1) : (tx_shift_q << 1);
  assign rx_next = f_lsb_q ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                           : {rx_shift_q[DATA_W-2:0], mosi_s};

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Engine next-state and per-cycle strobes; disable or deselect overrides all
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: if (ss_fall) state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        state_d = StXfer;
      end
      StXfer: begin
        sample = smp_edge;
        shift  = sh_edge;
      end
      default: state_d = StIdle;
    endcase
    if (!ctrl_q[0] || ss_rise) begin
      state_d = StIdle;
      load    = 1'b0;
      sample  = 1'b0;
      shift   = 1'b0;
    end
  end

  // Engine registers: frame mode latch, shifters, bit counter, MISO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      f_cpol_q   <= 1'b0;
      f_cpha_q   <= 1'b0;
      f_lsb_q    <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      first_q    <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && state_d == StLoad) begin
        f_cpol_q <= ctrl_q[1];
        f_cpha_q <= ctrl_q[2];
        f_lsb_q  <= ctrl_q[3];
      end
      if (state_d == StIdle) begin
        miso_q <= 1'b0;
      end else if (load) begin
        tx_shift_q <= tx_word;
        miso_q     <= first_bit(tx_word, f_lsb_q);
        first_q    <= f_cpha_q;
        bit_cnt_q  <= '0;
      end else begin
        if (sample) begin
          rx_shift_q <= rx_next;
          bit_cnt_q  <= word_done ? '0 : bit_cnt_q + BIT_W'(1);
        end
        // After a reload the next shift edge presents bit 0 rather than advancing
        if (word_done) begin
          tx_shift_q <= tx_word;
          first_q    <= 1'b1;
        end else if (shift) begin
          if (first_q) begin
            miso_q  <= first_bit(tx_shift_q, f_lsb_q);
            first_q <= 1'b0;
          end else begin
            tx_shift_q <= tx_adv;
            miso_q     <= first_bit(tx_adv, f_lsb_q);
          end
        end
      end
    end
  end

  // TX FIFO pointers and count; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || tx_flush) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + PTR_W'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_W'(1);
      if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CNT_W'(1);
    end
  end

  // RX FIFO pointers and count; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || rx_flush) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + PTR_W'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PTR_W'(1);
      if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CNT_W'(1);
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CNT_W'(1);
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.writedata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_next;
  end

  // CTRL and sticky flags; a new event outranks a same-cycle W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      rx_ovr_q <= 1'b0;
      tx_unr_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= bus.writedata[3:0];
      rx_ovr_q <= (rx_ovr_q & ~(wr_status & bus.writedata[5]))
                | (word_done && rx_full && !rx_pop);
      tx_unr_q <= (tx_unr_q & ~(wr_status & bus.writedata[6])) | (tx_take && tx_empty);
    end
  end

  logic [31:0] status;
  assign status = {8'd0, 8'(tx_cnt_q), 8'(rx_cnt_q), 1'b0, tx_unr_q, rx_ovr_q,
                   tx_full, tx_empty, rx_full, rx_empty, ~ss_s};

`ifdef SPI_SLAVE_IRQ_EN
  logic [3:0] irq_en_q;
  logic       irq_q;
  // IRQ enable register and registered interrupt line
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (bus.write && bus.address == 6'd4) irq_en_q <= bus.writedata[3:0];
      irq_q <= |(irq_en_q & {tx_unr_q, rx_ovr_q, tx_empty, ~rx_empty});
    end
  end
  assign irq = irq_q;
`endif

  // Read mux over pre-write state
  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (bus.address)
      6'd0: rd_data[3:0] = ctrl_q;
      6'd1: rd_data = status;
      6'd3: if (!rx_empty) rd_data[DATA_W-1:0] = rx_mem[rx_rd_q];
`ifdef SPI_SLAVE_IRQ_EN
      6'd4: rd_data[3:0] = irq_en_q;
`endif
      default: ;
    endcase
  end

  // Fixed latency-1 read response; data holds until the next read
  logic [31:0] rdata_q;
  logic        rdv_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      rdv_q <= bus.read;
      if (bus.read) rdata_q <= rd_data;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.waitrequest   = 1'b0;
  assign MISO              = miso_q;

  logic unused_bits;
  assign unused_bits = ^{bus.byteenable, bus.burstcount, bus.writedata, sync3_q[1]};

endmodule

// File: tb/tb_spi_slave_mm.sv
// tb_spi_slave_mm: directed bench for spi_slave_mm; a 32-bit/depth-8 instance
// and an 8-bit/depth-4 instance share the SPI master pins.
module tb_spi_slave_mm;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic miso32, miso8;
  logic cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;

  logic [5:0]  b_addr  = '0;
  logic        b_read  = 1'b0, b_write = 1'b0, b_dbg = 1'b0, sel = 1'b0;
  logic [31:0] b_wdata = '0;
  logic        rdv_seen;
  logic        mon_on = 1'b0, miso_acc;
  logic [7:0]  mtx [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_slave_mm_if if32 ();
  spi_slave_mm_if if8 ();

  assign if32.address     = b_addr;
  assign if32.read        = b_read & ~sel;
  assign if32.write       = b_write & ~sel;
  assign if32.writedata   = b_wdata;
  assign if32.byteenable  = 4'hF;
  assign if32.burstcount  = 1'b1;
  assign if32.debugaccess = b_dbg;
  assign if8.address      = b_addr;
  assign if8.read         = b_read & sel;
  assign if8.write        = b_write & sel;
  assign if8.writedata    = b_wdata;
  assign if8.byteenable   = 4'hF;
  assign if8.burstcount   = 1'b1;
  assign if8.debugaccess  = b_dbg;

`ifdef SPI_SLAVE_IRQ_EN
  logic irq32, irq8;
`endif

  spi_slave_mm #(.DATA_W(32), .FIFO_DEPTH(8)) dut32 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if32),
    .SCLK (sclk),
    .MOSI (mosi),
    .SS_n (ss_n),
    .MISO (miso32)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq  (irq32)
`endif
  );

  spi_slave_mm #(.DATA_W(8), .FIFO_DEPTH(4)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if8),
    .SCLK (sclk),
    .MOSI (mosi),
    .SS_n (ss_n),
    .MISO (miso8)
`ifdef SPI_SLAVE_IRQ_EN
    ,
    .irq  (irq8)
`endif
  );

  // Tracks whether MISO of the 8-bit slave ever goes high while monitoring
  always @(posedge clk) begin
    if (mon_on) miso_acc <= miso_acc | miso8;
    else        miso_acc <= 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic s, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = s; b_addr = a; b_wdata = d; b_write = 1'b1;
    @(negedge clk);
    b_write = 1'b0;
  endtask

  task automatic bus_read(input logic s, input logic [5:0] a, input logic dbg,
                          output logic [31:0] d);
    @(negedge clk);
    sel = s; b_addr = a; b_dbg = dbg; b_read = 1'b1;
    @(negedge clk);
    b_read = 1'b0; b_dbg = 1'b0;
    d        = s ? if8.readdata : if32.readdata;
    rdv_seen = s ? if8.readdatavalid : if32.readdatavalid;
  endtask

  task automatic spi_begin();
    sclk = cpol; mosi = 1'b0;
    #(HALF);
    ss_n = 1'b0;
    #(HALF);
  endtask

  task automatic spi_end();
    #(HALF);
    ss_n = 1'b1;
    #(2 * HALF);
  endtask

  // One word (or the first nbits of it) as SPI master; rx collects MISO at the sample edge
  task automatic spi_word(input logic [31:0] tx, input int width, input int nbits,
                          input logic s, output logic [31:0] rx);
    int k;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      k = lsb ? i : width - 1 - i;
      if (!cpha) begin
        mosi = tx[k];
        #(HALF);
        sclk = ~sclk;
        rx[k] = s ? miso8 : miso32;
        #(HALF);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = tx[k];
        #(HALF);
        sclk = ~sclk;
        rx[k] = s ? miso8 : miso32;
        #(HALF);
      end
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, r, acc;
    logic [7:0]  bv;
    mtx = '{8'hA5, 8'hC3, 8'h81, 8'h6E};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rdv", {31'b0, if32.readdatavalid}, 32'h0);
    check_eq("rst_miso", {31'b0, miso32}, 32'h0);
    check_eq("rst_rdata", if32.readdata, 32'h0);
    check_eq("waitreq", {31'b0, if32.waitrequest}, 32'h0);
    bus_read(1'b0, 6'd1, 1'b0, d);
    check_eq("rst_status", d, 32'h0000_000A);
    check_eq("rdv_lat1", {31'b0, rdv_seen}, 32'h1);
    @(negedge clk);
    check_eq("rdv_pulse", {31'b0, if32.readdatavalid}, 32'h0);

    // Mode 0, 32-bit word
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    bus_write(1'b0, 6'd0, 32'h1);
    bus_write(1'b0, 6'd2, 32'hA5A5_0F0F);
    bus_read(1'b0, 6'd1, 1'b0, d);
    check_eq("m0_status_pre", d, 32'h0001_0002);
    spi_begin();
    spi_word(32'h1234_5678, 32, 32, 1'b0, r);
    spi_end();
    check_eq("m0_miso", r, 32'hA5A5_0F0F);
    bus_read(1'b0, 6'd1, 1'b0, d);
    check_eq("m0_status_post", d, 32'h0000_0148);
    bus_read(1'b0, 6'd3, 1'b0, d);
    check_eq("m0_rxdata", d, 32'h1234_5678);
    bus_read(1'b0, 6'd1, 1'b0, d);
    check_eq("m0_status_pop", d, 32'h0000_004A);

    // Abort after 13 bits, then a clean frame
    spi_begin();
    spi_word(32'hFFFF_0000, 32, 13, 1'b0, r);
    spi_end();
    bus_read(1'b0, 6'd1, 1'b0, d);
    check_eq("abort_status", d, 32'h0000_004A);
    check_eq("abort_miso", {31'b0, miso32}, 32'h0);
    bus_write(1'b0, 6'd2, 32'hDEAD_BEEF);
    spi_begin();
    spi_word(32'hCAFE_F00D, 32, 32, 1'b0, r);
    spi_end();
    check_eq("after_abort_miso", r, 32'hDEAD_BEEF);
    bus_read(1'b0, 6'd3, 1'b0, d);
    check_eq("after_abort_rx", d, 32'hCAFE_F00D);
    bus_write(1'b0, 6'd0, 32'h0);

    // All four modes, 8-bit LSB first
    for (int m = 0; m < 4; m++) begin
      cpol = m[1]; cpha = m[0]; lsb = 1'b1;
      bus_write(1'b1, 6'd0, {28'h0, 1'b1, cpha, cpol, 1'b1});
      bus_write(1'b1, 6'd2, {24'h0, mtx[m]});
      spi_begin();
      spi_word(32'h3C, 8, 8, 1'b1, r);
      spi_end();
      check_eq($sformatf("mode%0d_miso", m), r, {24'h0, mtx[m]});
      bus_read(1'b1, 6'd3, 1'b0, d);
      check_eq($sformatf("mode%0d_rx", m), d, 32'h3C);
    end

    // Overrun and underrun, depth 4, five words back-to-back with TX empty
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    bus_write(1'b1, 6'd1, 32'h60);
    bus_write(1'b1, 6'd0, 32'h1);
    acc = '0;
    mon_on = 1'b1;
    spi_begin();
    for (int w = 0; w < 5; w++) begin
      bv = 8'(17 * (w + 1));
      spi_word({24'h0, bv}, 8, 8, 1'b1, r);
      acc = acc | r;
    end
    spi_end();
    check_eq("ovr_miso_zero", acc | {31'b0, miso_acc}, 32'h0);
    mon_on = 1'b0;
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("ovr_status", d, 32'h0000_046C);
    bus_write(1'b1, 6'd1, 32'h60);
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("ovr_w1c", d, 32'h0000_040C);
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b1, 6'd3, 1'b0, d);
      check_eq($sformatf("ovr_drain%0d", i), d, 32'(17 * (i + 1)));
    end

    // debugaccess peek leaves the head in place
    spi_begin();
    spi_word(32'hA1, 8, 8, 1'b1, r);
    spi_word(32'hB2, 8, 8, 1'b1, r);
    spi_end();
    bus_read(1'b1, 6'd3, 1'b1, d);
    check_eq("dbg_peek", d, 32'hA1);
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("dbg_cnt", (d >> 8) & 32'hFF, 32'h2);
    bus_read(1'b1, 6'd3, 1'b0, d);
    check_eq("pop_a1", d, 32'hA1);
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("pop_cnt", (d >> 8) & 32'hFF, 32'h1);
    bus_read(1'b1, 6'd3, 1'b0, d);
    check_eq("pop_b2", d, 32'hB2);
    bus_read(1'b1, 6'd3, 1'b0, d);
    check_eq("pop_empty", d, 32'h0);

    // TX flush, CTRL readback, write-only and unmapped reads
    bus_write(1'b1, 6'd0, 32'h0);
    bus_write(1'b1, 6'd2, 32'h01);
    bus_write(1'b1, 6'd2, 32'h02);
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("tx_cnt2", (d >> 16) & 32'hFF, 32'h2);
    bus_write(1'b1, 6'd0, 32'h21);
    bus_read(1'b1, 6'd1, 1'b0, d);
    check_eq("tx_flushed", (d >> 16) & 32'hFF, 32'h0);
    bus_read(1'b1, 6'd0, 1'b0, d);
    check_eq("ctrl_rb", d, 32'h1);
    bus_read(1'b1, 6'd2, 1'b0, d);
    check_eq("txdata_rd0", d, 32'h0);
    bus_read(1'b1, 6'd9, 1'b0, d);
    check_eq("unmapped_rd0", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
